mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/rapid_pkg.sv | 54 +++++
 rtl/mem_stage_if.sv | 23 ++
 rtl/load_align.sv | 34 +++
 rtl/mem_stage.sv | 157 +++++++++++++++
 tb/tb_mem_stage.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/rapid_pkg.sv
// Shared types and encodings for the rapid pipeline memory stage.
// Holds the FSM state enum, trap causes, fcs_opcode access encodings and small helpers.
package rapid_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_e;

    localparam logic [1:0] TRAP_MISALIGNED  = 2'd1;
    localparam logic [1:0] TRAP_BUS_TIMEOUT = 2'd2;

    // fcs_opcode[1:0] selects the access width, fcs_opcode[2] selects zero extension
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam int         EXT_UNSIGNED_BIT = 2;

    typedef struct packed {
        logic        mem;
        logic        iop;
        logic [2:0]  fcs_opcode;
        logic [4:0]  rd;
        logic [31:0] debug_instruction;
    } control_mem_s;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            default:   return addr_lo != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 4'b0001 << addr_lo;
            SIZE_HALF: return 4'b0011 << addr_lo;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] replicate_store(input logic [1:0] size, input logic [XLEN-1:0] data);
        case (size)
            SIZE_BYTE: return {(XLEN/8){data[7:0]}};
            SIZE_HALF: return {(XLEN/16){data[15:0]}};
            default:   return data;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage (master) and the memory/interconnect (slave).
interface mem_stage_if #(parameter int XLEN = rapid_pkg::XLEN);

    logic            dmem_req;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_addr;
    logic [XLEN-1:0] dmem_wdata;
    logic [3:0]      dmem_be;
    logic            dmem_gnt;
    logic            dmem_rvalid;
    logic [XLEN-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/load_align.sv
// Selects the addressed byte/half lane of a read word and sign- or zero-extends it.
module load_align
    import rapid_pkg::*;
#(
    parameter int XLEN = rapid_pkg::XLEN
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr_lo,
    input  logic [2:0]      fcs_opcode,
    output logic [XLEN-1:0] data
);

    logic [15:0] lane;
    logic        sign_fill;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        data      = rdata;
        lane      = 16'(rdata >> {addr_lo, 3'b000});
        sign_fill = 1'b0;
        case (fcs_opcode[1:0])
            SIZE_BYTE: begin
                sign_fill = ~fcs_opcode[EXT_UNSIGNED_BIT] & lane[7];
                data      = {{(XLEN-8){sign_fill}}, lane[7:0]};
            end
            SIZE_HALF: begin
                sign_fill = ~fcs_opcode[EXT_UNSIGNED_BIT] & lane[15];
                data      = {{(XLEN-16){sign_fill}}, lane};
            end
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: passes ALU results through and runs loads/stores on the data bus,
// raising a one-cycle trap on misaligned access or bus timeout.
module mem_stage
    import rapid_pkg::*;
#(
    parameter int XLEN    = rapid_pkg::XLEN,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    output logic              o_ready,
    input  control_mem_s      i_control_signal,
    input  logic [XLEN-1:0]   i_rd_output,
    input  logic [XLEN-1:0]   i_memory_data,
    mem_stage_if.master       dmem,
    output logic              o_wb_valid,
    output logic [4:0]        o_wb_rd,
    output logic [XLEN-1:0]   o_wb_data,
    output logic              o_wb_we,
    output logic              o_trap,
    output logic [1:0]        o_trap_cause,
    output logic [XLEN-1:0]   o_trap_addr
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    mem_state_e        state, state_next;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   addr_q, wdata_q, load_data;
    logic [3:0]        be_q;
    logic [2:0]        op_q;
    logic [4:0]        rd_q;
    logic              store_q;
    logic              accept, misaligned, start_mem, timed_out;
    logic              store_done, load_done, timeout_trap;
    logic              unused_debug;

    assign unused_debug = ^i_control_signal.debug_instruction;

    assign accept       = i_valid && (state == IDLE);
    assign misaligned   = is_misaligned(i_control_signal.fcs_opcode[1:0], i_rd_output[1:0]);
    assign start_mem    = accept && i_control_signal.mem && !misaligned;
    assign timed_out    = (cnt == CNT_W'(TIMEOUT - 1));
    assign store_done   = (state == REQ) && dmem.dmem_gnt && store_q;
    assign load_done    = !store_q && dmem.dmem_rvalid &&
                          ((state == WAIT) || ((state == REQ) && dmem.dmem_gnt));
    assign timeout_trap = timed_out && (((state == REQ) && !dmem.dmem_gnt) ||
                                       ((state == WAIT) && !dmem.dmem_rvalid));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rst_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start_mem) state_next = REQ;
            REQ: begin
                if (dmem.dmem_gnt) state_next = (store_q || dmem.dmem_rvalid) ? IDLE : WAIT;
                else if (timed_out) state_next = IDLE;
            end
            WAIT: if (dmem.dmem_rvalid || timed_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready       = (state == IDLE);
        dmem.dmem_req = (state == REQ);
        dmem.dmem_we  = (state == REQ) && store_q;
    end

    assign dmem.dmem_addr  = {addr_q[XLEN-1:2], 2'b00};
    assign dmem.dmem_wdata = wdata_q;
    assign dmem.dmem_be    = be_q;

    // Counts cycles spent in the current state; cleared whenever the state changes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else if (state != IDLE)       cnt <= cnt + 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            store_q <= 1'b0;
        end else if (start_mem) begin
            addr_q  <= i_rd_output;
            wdata_q <= replicate_store(i_control_signal.fcs_opcode[1:0], i_memory_data);
            be_q    <= byte_enables(i_control_signal.fcs_opcode[1:0], i_rd_output[1:0]);
            op_q    <= i_control_signal.fcs_opcode;
            rd_q    <= i_control_signal.rd;
            store_q <= i_control_signal.iop;
        end
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata      (dmem.dmem_rdata),
        .addr_lo    (addr_q[1:0]),
        .fcs_opcode (op_q),
        .data       (load_data)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_valid <= 1'b0;
            o_wb_rd    <= '0;
            o_wb_data  <= '0;
            o_wb_we    <= 1'b0;
        end else begin
            o_wb_valid <= 1'b0;
            if (accept && !i_control_signal.mem) begin
                o_wb_valid <= 1'b1;
                o_wb_rd    <= i_control_signal.rd;
                o_wb_data  <= i_rd_output;
                o_wb_we    <= (i_control_signal.rd != 5'd0);
            end else if (store_done) begin
                o_wb_valid <= 1'b1;
                o_wb_rd    <= rd_q;
                o_wb_we    <= 1'b0;
            end else if (load_done) begin
                o_wb_valid <= 1'b1;
                o_wb_rd    <= rd_q;
                o_wb_data  <= load_data;
                o_wb_we    <= (rd_q != 5'd0);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_trap       <= 1'b0;
            o_trap_cause <= '0;
            o_trap_addr  <= '0;
        end else begin
            o_trap <= 1'b0;
            if (accept && i_control_signal.mem && misaligned) begin
                o_trap       <= 1'b1;
                o_trap_cause <= TRAP_MISALIGNED;
                o_trap_addr  <= i_rd_output;
            end else if (timeout_trap) begin
                o_trap       <= 1'b1;
                o_trap_cause <= TRAP_BUS_TIMEOUT;
                o_trap_addr  <= addr_q;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, stores, load extraction, traps and reset.
module tb_mem_stage;
    import rapid_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic         ready;
    control_mem_s ctrl;
    logic [31:0]  rd_output;
    logic [31:0]  memory_data;
    logic         wb_valid;
    logic [4:0]   wb_rd;
    logic [31:0]  wb_data;
    logic         wb_we;
    logic         trap;
    logic [1:0]   trap_cause;
    logic [31:0]  trap_addr;

    int n_asserts = 0;
    int n_fail    = 0;

    mem_stage_if #(.XLEN(32)) dmem ();

    mem_stage #(.XLEN(32), .TIMEOUT(8)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_valid          (valid),
        .o_ready          (ready),
        .i_control_signal (ctrl),
        .i_rd_output      (rd_output),
        .i_memory_data    (memory_data),
        .dmem             (dmem),
        .o_wb_valid       (wb_valid),
        .o_wb_rd          (wb_rd),
        .o_wb_data        (wb_data),
        .o_wb_we          (wb_we),
        .o_trap           (trap),
        .o_trap_cause     (trap_cause),
        .o_trap_addr      (trap_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic control_mem_s mk_ctrl(input logic mem, input logic iop,
                                             input logic [2:0] op, input logic [4:0] rd);
        control_mem_s c;
        c.mem = mem;
        c.iop = iop;
        c.fcs_opcode = op;
        c.rd = rd;
        c.debug_instruction = 32'h0000_0013;
        return c;
    endfunction

    task automatic issue(input control_mem_s c, input logic [31:0] addr, input logic [31:0] data);
        valid = 1'b1;
        ctrl = c;
        rd_output = addr;
        memory_data = data;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_asserts++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", ready); end
        n_asserts++; if (dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", dmem.dmem_req); end
        n_asserts++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wb_valid: got %b expected 0", wb_valid); end
        n_asserts++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b expected 0", trap); end
        n_asserts++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL reset_wb_data: got %h expected 0", wb_data); end
        n_asserts++; if (dmem.dmem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", dmem.dmem_addr); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu();
        issue(mk_ctrl(1'b0, 1'b0, 3'b000, 5'd5), 32'h0000_1234, 32'h0);
        n_asserts++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL alu_wb_valid: got %b expected 1", wb_valid); end
        n_asserts++; if (wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_wb_data: got %h expected 00001234", wb_data); end
        n_asserts++; if (wb_we !== 1'b1) begin n_fail++; $display("FAIL alu_wb_we: got %b expected 1", wb_we); end
        n_asserts++; if (wb_rd !== 5'd5) begin n_fail++; $display("FAIL alu_wb_rd: got %0d expected 5", wb_rd); end
        n_asserts++; if (dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL alu_req: got %b expected 0", dmem.dmem_req); end
        @(negedge clk);
        n_asserts++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_idle_valid: got %b expected 0", wb_valid); end
        n_asserts++; if (wb_data !== 32'h0000_1234) begin n_fail++; $display("FAIL alu_hold_data: got %h expected 00001234", wb_data); end
        issue(mk_ctrl(1'b0, 1'b0, 3'b000, 5'd0), 32'h0000_0055, 32'h0);
        n_asserts++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL alu_rd0: got valid=%b we=%b expected valid=1 we=0", wb_valid, wb_we); end
    endtask

    task automatic test_back_to_back();
        valid = 1'b1;
        ctrl = mk_ctrl(1'b0, 1'b0, 3'b000, 5'd1);
        rd_output = 32'hAAAA_0001;
        @(negedge clk);
        n_asserts++; if (wb_data !== 32'hAAAA_0001 || wb_rd !== 5'd1) begin n_fail++; $display("FAIL b2b_first: got %h rd=%0d expected aaaa0001 rd=1", wb_data, wb_rd); end
        n_asserts++; if (ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b expected 1", ready); end
        ctrl = mk_ctrl(1'b0, 1'b0, 3'b000, 5'd2);
        rd_output = 32'hBBBB_0002;
        @(negedge clk);
        valid = 1'b0;
        n_asserts++; if (wb_valid !== 1'b1 || wb_data !== 32'hBBBB_0002 || wb_rd !== 5'd2) begin n_fail++; $display("FAIL b2b_second: got v=%b %h rd=%0d expected v=1 bbbb0002 rd=2", wb_valid, wb_data, wb_rd); end
        @(negedge clk);
    endtask

    task automatic test_store_sb();
        int req_cycles = 0;
        issue(mk_ctrl(1'b1, 1'b1, 3'b000, 5'd0), 32'h0000_0103, 32'h0000_00AB);
        for (int i = 0; i < 3; i++) begin
            if (dmem.dmem_req === 1'b1) req_cycles++;
            n_asserts++; if (dmem.dmem_be !== 4'b1000) begin n_fail++; $display("FAIL sb_be[%0d]: got %b expected 1000", i, dmem.dmem_be); end
            n_asserts++; if (dmem.dmem_wdata !== 32'hABAB_ABAB) begin n_fail++; $display("FAIL sb_wdata[%0d]: got %h expected abababab", i, dmem.dmem_wdata); end
            n_asserts++; if (dmem.dmem_addr !== 32'h0000_0100 || dmem.dmem_we !== 1'b1) begin n_fail++; $display("FAIL sb_addr_we[%0d]: got %h we=%b expected 00000100 we=1", i, dmem.dmem_addr, dmem.dmem_we); end
            n_asserts++; if (ready !== 1'b0) begin n_fail++; $display("FAIL sb_ready[%0d]: got %b expected 0", i, ready); end
            if (i == 2) dmem.dmem_gnt = 1'b1;
            @(negedge clk);
        end
        dmem.dmem_gnt = 1'b0;
        n_asserts++; if (req_cycles != 3) begin n_fail++; $display("FAIL sb_req_cycles: got %0d expected 3", req_cycles); end
        n_asserts++; if (dmem.dmem_req !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL sb_done: got req=%b ready=%b expected req=0 ready=1", dmem.dmem_req, ready); end
        n_asserts++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL sb_wb: got valid=%b we=%b expected valid=1 we=0", wb_valid, wb_we); end
    endtask

    task automatic test_store_sizes();
        logic [31:0] addr  [2] = '{32'h0000_0102, 32'h0000_0100};
        logic [2:0]  op    [2] = '{3'b001, 3'b010};
        logic [31:0] data  [2] = '{32'h1234_BEEF, 32'hCAFE_F00D};
        logic [3:0]  ex_be [2] = '{4'b1100, 4'b1111};
        logic [31:0] ex_wd [2] = '{32'hBEEF_BEEF, 32'hCAFE_F00D};
        for (int i = 0; i < 2; i++) begin
            issue(mk_ctrl(1'b1, 1'b1, op[i], 5'd0), addr[i], data[i]);
            n_asserts++; if (dmem.dmem_be !== ex_be[i]) begin n_fail++; $display("FAIL st_be[%0d]: got %b expected %b", i, dmem.dmem_be, ex_be[i]); end
            n_asserts++; if (dmem.dmem_wdata !== ex_wd[i]) begin n_fail++; $display("FAIL st_wdata[%0d]: got %h expected %h", i, dmem.dmem_wdata, ex_wd[i]); end
            dmem.dmem_gnt = 1'b1;
            @(negedge clk);
            dmem.dmem_gnt = 1'b0;
            n_asserts++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin n_fail++; $display("FAIL st_wb[%0d]: got valid=%b we=%b expected valid=1 we=0", i, wb_valid, wb_we); end
        end
    endtask

    task automatic test_load_extract();
        logic [31:0] addr  [6] = '{32'h102, 32'h102, 32'h102, 32'h102, 32'h100, 32'h101};
        logic [2:0]  op    [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
        logic [4:0]  rd    [6] = '{5'd3, 5'd3, 5'd4, 5'd4, 5'd0, 5'd7};
        logic [31:0] rdata [6] = '{32'h0080_0000, 32'h0080_0000, 32'h8001_0000, 32'h8001_0000, 32'hDEAD_BEEF, 32'h0000_7F00};
        logic        same  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [3:0]  ex_be [6] = '{4'b0100, 4'b0100, 4'b1100, 4'b1100, 4'b1111, 4'b0010};
        logic [31:0] ex_d  [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001, 32'h0000_8001, 32'hDEAD_BEEF, 32'h0000_007F};
        logic        ex_we [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            issue(mk_ctrl(1'b1, 1'b0, op[i], rd[i]), addr[i], 32'h0);
            n_asserts++; if (dmem.dmem_req !== 1'b1 || dmem.dmem_we !== 1'b0 || dmem.dmem_be !== ex_be[i]) begin n_fail++; $display("FAIL ld_req[%0d]: got req=%b we=%b be=%b expected req=1 we=0 be=%b", i, dmem.dmem_req, dmem.dmem_we, dmem.dmem_be, ex_be[i]); end
            dmem.dmem_gnt = 1'b1;
            if (same[i]) begin dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = rdata[i]; end
            @(negedge clk);
            dmem.dmem_gnt = 1'b0;
            dmem.dmem_rvalid = 1'b0;
            if (!same[i]) begin
                n_asserts++; if (ready !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL ld_wait[%0d]: got ready=%b wb_valid=%b expected 0 0", i, ready, wb_valid); end
                dmem.dmem_rvalid = 1'b1;
                dmem.dmem_rdata = rdata[i];
                @(negedge clk);
                dmem.dmem_rvalid = 1'b0;
            end
            n_asserts++; if (wb_valid !== 1'b1 || wb_data !== ex_d[i]) begin n_fail++; $display("FAIL ld_data[%0d]: got valid=%b %h expected valid=1 %h", i, wb_valid, wb_data, ex_d[i]); end
            n_asserts++; if (wb_we !== ex_we[i] || wb_rd !== rd[i] || ready !== 1'b1) begin n_fail++; $display("FAIL ld_wb[%0d]: got we=%b rd=%0d ready=%b expected we=%b rd=%0d ready=1", i, wb_we, wb_rd, ready, ex_we[i], rd[i]); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] addr [3] = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0203};
        logic [2:0]  op   [3] = '{3'b010, 3'b001, 3'b010};
        logic        iop  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            issue(mk_ctrl(1'b1, iop[i], op[i], 5'd8), addr[i], 32'h1);
            n_asserts++; if (dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL mis_side[%0d]: got req=%b wb_valid=%b ready=%b expected 0 0 1", i, dmem.dmem_req, wb_valid, ready); end
            n_asserts++; if (trap !== 1'b1 || trap_cause !== 2'd1 || trap_addr !== addr[i]) begin n_fail++; $display("FAIL mis_trap[%0d]: got trap=%b cause=%0d addr=%h expected 1 1 %h", i, trap, trap_cause, trap_addr, addr[i]); end
            @(negedge clk);
            n_asserts++; if (trap !== 1'b0 || dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL mis_pulse[%0d]: got trap=%b req=%b expected 0 0", i, trap, dmem.dmem_req); end
        end
    endtask

    task automatic test_timeout();
        int wait_cycles = 0;
        int req_cycles = 0;
        issue(mk_ctrl(1'b1, 1'b0, 3'b010, 5'd6), 32'h0000_0200, 32'h0);
        dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        for (int i = 0; i < 20 && trap !== 1'b1; i++) begin
            wait_cycles++;
            @(negedge clk);
        end
        n_asserts++; if (wait_cycles != 8) begin n_fail++; $display("FAIL to_wait_cycles: got %0d expected 8", wait_cycles); end
        n_asserts++; if (trap !== 1'b1 || trap_cause !== 2'd2 || trap_addr !== 32'h0000_0200) begin n_fail++; $display("FAIL to_wait_trap: got trap=%b cause=%0d addr=%h expected 1 2 00000200", trap, trap_cause, trap_addr); end
        n_asserts++; if (ready !== 1'b1 || dmem.dmem_req !== 1'b0 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL to_wait_idle: got ready=%b req=%b wb_valid=%b expected 1 0 0", ready, dmem.dmem_req, wb_valid); end
        @(negedge clk);
        issue(mk_ctrl(1'b1, 1'b1, 3'b010, 5'd0), 32'h0000_0300, 32'h5);
        for (int i = 0; i < 20 && trap !== 1'b1; i++) begin
            if (dmem.dmem_req === 1'b1) req_cycles++;
            @(negedge clk);
        end
        n_asserts++; if (req_cycles != 8) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 8", req_cycles); end
        n_asserts++; if (trap !== 1'b1 || trap_cause !== 2'd2 || dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL to_req_trap: got trap=%b cause=%0d req=%b expected 1 2 0", trap, trap_cause, dmem.dmem_req); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        issue(mk_ctrl(1'b1, 1'b0, 3'b010, 5'd9), 32'h0000_0400, 32'h0);
        dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0;
        n_asserts++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rm_in_wait: got ready=%b expected 0", ready); end
        rst_n = 1'b0;
        #1;
        n_asserts++; if (dmem.dmem_req !== 1'b0 || ready !== 1'b1 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async: got req=%b ready=%b wb_valid=%b expected 0 1 0", dmem.dmem_req, ready, wb_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        dmem.dmem_rvalid = 1'b1;
        dmem.dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        n_asserts++; if (wb_valid !== 1'b0 || dmem.dmem_req !== 1'b0) begin n_fail++; $display("FAIL rm_late_rvalid: got wb_valid=%b req=%b expected 0 0", wb_valid, dmem.dmem_req); end
        n_asserts++; if (wb_data !== 32'h0) begin n_fail++; $display("FAIL rm_wb_data: got %h expected 0", wb_data); end
        @(negedge clk);
        n_asserts++; if (wb_valid !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL rm_settle: got wb_valid=%b ready=%b expected 0 1", wb_valid, ready); end
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        ctrl = mk_ctrl(1'b0, 1'b0, 3'b000, 5'd0);
        rd_output = '0;
        memory_data = '0;
        dmem.dmem_gnt = 1'b0;
        dmem.dmem_rvalid = 1'b0;
        dmem.dmem_rdata = '0;
        test_reset();
        test_alu();
        test_back_to_back();
        test_store_sb();
        test_store_sizes();
        test_load_extract();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
